// File: rtl/timer_pkg.sv
// Shared constants for the countdown-timer front end: FSM encoding,
// default debounce prescaler modulo and the key indices used by the timer FSM.
package timer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  localparam int unsigned SAMPLE_PRESC_MODULO_DEF = 1000;

  localparam int unsigned KEY_START  = 0;
  localparam int unsigned KEY_STOP   = 1;
  localparam int unsigned KEY_UP_MIN = 2;
  localparam int unsigned KEY_DN_MIN = 3;

endpackage

// File: rtl/key_event_arbiter_rr_pick.sv
// Round-robin picker: first set pending bit searching upward from i_rr_ptr,
// wrapping modulo KEYS_NUM. Purely combinational.
module rr_pick #(
  parameter int unsigned KEYS_NUM = 4,
  parameter int unsigned CODE_W   = $clog2(KEYS_NUM)
) (
  input  logic [KEYS_NUM-1:0] i_pending,
  input  logic [CODE_W-1:0]   i_rr_ptr,
  output logic                o_found_c,
  output logic [CODE_W-1:0]   o_code_c
);

  logic [CODE_W:0] w_idx;

  // Extra index bit holds ptr+i before the wrap subtraction.
  always_comb begin
    o_found_c = 1'b0;
    o_code_c  = '0;
    w_idx     = '0;
    for (int unsigned i = 0; i < KEYS_NUM; i++) begin
      w_idx = {1'b0, i_rr_ptr} + (CODE_W+1)'(i);
      if (w_idx >= (CODE_W+1)'(KEYS_NUM)) begin
        w_idx = w_idx - (CODE_W+1)'(KEYS_NUM);
      end
      if (!o_found_c && (w_idx < (CODE_W+1)'(KEYS_NUM)) && i_pending[w_idx[CODE_W-1:0]]) begin
        o_found_c = 1'b1;
        o_code_c  = w_idx[CODE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Debouncer-bank controller: sampling strobe, repeat enables, pending latch and
// round-robin valid/ack event stream. KEY_ARB_OVERFLOW_EN adds sticky OVF/OVF_CLR.
module key_event_arbiter
  import timer_pkg::*;
#(
  parameter int unsigned          KEYS_NUM            = 4,
  parameter int unsigned          SAMPLE_PRESC_MODULO = SAMPLE_PRESC_MODULO_DEF,
  parameter logic [KEYS_NUM-1:0]  REPEAT_MASK         = KEYS_NUM'(4'b0011),
  localparam int unsigned         CODE_W              = $clog2(KEYS_NUM)
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic [KEYS_NUM-1:0] KEY_UP,
  input  logic [KEYS_NUM-1:0] KEY_EN,
  input  logic                LOCK,
  output logic                SAMPLE_CE,
  output logic [KEYS_NUM-1:0] REP_EN,
  output logic                EVT_VALID,
  output logic [CODE_W-1:0]   EVT_CODE,
`ifdef KEY_ARB_OVERFLOW_EN
  input  logic                OVF_CLR,
  output logic                OVF,
`endif
  input  logic                EVT_ACK
);

  localparam int unsigned PRESC_W = $clog2(SAMPLE_PRESC_MODULO);

  logic [PRESC_W-1:0]  r_presc;
  logic                r_sample_ce;
  logic [KEYS_NUM-1:0] r_rep_en;
  logic [KEYS_NUM-1:0] r_pending;
  logic [CODE_W-1:0]   r_rr_ptr;
  logic [CODE_W-1:0]   r_evt_code;
  logic                r_evt_valid;
  arb_state_t          r_state;

  logic [KEYS_NUM-1:0] w_set;
  logic [KEYS_NUM-1:0] w_clr;
  logic                w_one_key;
  logic                w_found;
  logic [CODE_W-1:0]   w_pick;
  logic [CODE_W-1:0]   w_ptr_next;

  assign w_set      = LOCK ? '0 : KEY_UP;
  assign w_clr      = (r_evt_valid && EVT_ACK) ? (KEYS_NUM'(1) << r_evt_code) : '0;
  assign w_one_key  = (KEY_EN != '0) && ((KEY_EN & (KEY_EN - KEYS_NUM'(1))) == '0);
  assign w_ptr_next = (r_evt_code == CODE_W'(KEYS_NUM - 1)) ? '0 : r_evt_code + CODE_W'(1);

  // Debounce sampling strobe: pulse the cycle after the counter holds MODULO-1.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_presc     <= '0;
      r_sample_ce <= 1'b0;
    end else begin
      r_sample_ce <= (r_presc == PRESC_W'(SAMPLE_PRESC_MODULO - 1));
      r_presc     <= (r_presc == PRESC_W'(SAMPLE_PRESC_MODULO - 1)) ? '0 : r_presc + PRESC_W'(1);
    end
  end

  // Single held key only: chords never auto-repeat.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_rep_en <= '0;
    end else begin
      r_rep_en <= REPEAT_MASK & KEY_EN & {KEYS_NUM{w_one_key}};
    end
  end

  // Set beats a coincident clear so a re-press during the ack is not lost.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  rr_pick #(
    .KEYS_NUM (KEYS_NUM),
    .CODE_W   (CODE_W)
  ) u_rr_pick (
    .i_pending (r_pending),
    .i_rr_ptr  (r_rr_ptr),
    .o_found_c (w_found),
    .o_code_c  (w_pick)
  );

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state     <= ST_IDLE;
      r_evt_valid <= 1'b0;
      r_evt_code  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_evt_code  <= w_pick;
            r_evt_valid <= 1'b1;
            r_state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (EVT_ACK) begin
            r_evt_valid <= 1'b0;
            r_rr_ptr    <= w_ptr_next;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef KEY_ARB_OVERFLOW_EN
  logic r_ovf;
  logic w_merge;

  assign w_merge = |(w_set & r_pending & ~w_clr);

  // Sticky merge flag; a new merge outranks a clear request.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_ovf <= 1'b0;
    end else if (w_merge) begin
      r_ovf <= 1'b1;
    end else if (OVF_CLR) begin
      r_ovf <= 1'b0;
    end
  end

  assign OVF = r_ovf;
`endif

  assign SAMPLE_CE = r_sample_ce;
  assign REP_EN    = r_rep_en;
  assign EVT_VALID = r_evt_valid;
  assign EVT_CODE  = r_evt_code;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter (4 keys, modulo 1000, repeat mask 0011).
module tb_key_event_arbiter;

  logic       CLK;
  logic       CLR_N;
  logic [3:0] KEY_UP;
  logic [3:0] KEY_EN;
  logic       LOCK;
  logic       SAMPLE_CE;
  logic [3:0] REP_EN;
  logic       EVT_VALID;
  logic [1:0] EVT_CODE;
  logic       EVT_ACK;
`ifdef KEY_ARB_OVERFLOW_EN
  logic       OVF_CLR;
  logic       OVF;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  key_event_arbiter #(
    .KEYS_NUM            (4),
    .SAMPLE_PRESC_MODULO (1000),
    .REPEAT_MASK         (4'b0011)
  ) dut (
    .CLK       (CLK),
    .CLR_N     (CLR_N),
    .KEY_UP    (KEY_UP),
    .KEY_EN    (KEY_EN),
    .LOCK      (LOCK),
    .SAMPLE_CE (SAMPLE_CE),
    .REP_EN    (REP_EN),
    .EVT_VALID (EVT_VALID),
    .EVT_CODE  (EVT_CODE),
`ifdef KEY_ARB_OVERFLOW_EN
    .OVF_CLR   (OVF_CLR),
    .OVF       (OVF),
`endif
    .EVT_ACK   (EVT_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] key_en;
    logic [3:0] exp_rep;
  } rep_vec_t;

  typedef struct {
    logic [3:0] key_up;
    logic [1:0] exp_code;
  } key_vec_t;

  rep_vec_t rep_tab[8];
  key_vec_t key_tab[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // {valid, code} packed for one-shot offer comparisons
  function automatic logic [31:0] offer();
    return {29'd0, EVT_VALID, EVT_CODE};
  endfunction

  initial begin
    rep_tab[0] = '{4'b0001, 4'b0001};
    rep_tab[1] = '{4'b0011, 4'b0000};
    rep_tab[2] = '{4'b0100, 4'b0000};
    rep_tab[3] = '{4'b0010, 4'b0010};
    rep_tab[4] = '{4'b0000, 4'b0000};
    rep_tab[5] = '{4'b1000, 4'b0000};
    rep_tab[6] = '{4'b0110, 4'b0000};
    rep_tab[7] = '{4'b1111, 4'b0000};

    key_tab[0] = '{4'b0001, 2'd0};
    key_tab[1] = '{4'b0010, 2'd1};
    key_tab[2] = '{4'b0100, 2'd2};
    key_tab[3] = '{4'b1000, 2'd3};

    CLR_N   = 1'b0;
    KEY_UP  = '0;
    KEY_EN  = '0;
    LOCK    = 1'b0;
    EVT_ACK = 1'b0;
`ifdef KEY_ARB_OVERFLOW_EN
    OVF_CLR = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", 32'(EVT_VALID), 32'd0);
    check("rst_code", 32'(EVT_CODE), 32'd0);
    check("rst_rep_en", 32'(REP_EN), 32'd0);
    check("rst_sample_ce", 32'(SAMPLE_CE), 32'd0);
`ifdef KEY_ARB_OVERFLOW_EN
    check("rst_ovf", 32'(OVF), 32'd0);
`endif
    @(negedge CLK);
    CLR_N = 1'b1;

    // Prescaler: strobe after edges 1000, 2000, 3000 only
    for (int k = 1; k <= 3005; k++) begin
      step();
      check("sample_ce", 32'(SAMPLE_CE), (k % 1000 == 0) ? 32'd1 : 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      KEY_EN = rep_tab[i].key_en;
      step();
      check("rep_en", 32'(REP_EN), 32'(rep_tab[i].exp_rep));
    end
    KEY_EN = '0;

    // Single-key events, ack tied high; keys in order leaves rr_ptr at 0
    EVT_ACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      KEY_UP = key_tab[i].key_up;
      step();
      KEY_UP = '0;
      check("lat_early", 32'(EVT_VALID), 32'd0);
      step();
      check("single_offer", offer(), {29'd0, 1'b1, key_tab[i].exp_code});
      step();
      check("single_taken", 32'(EVT_VALID), 32'd0);
      step();
      check("single_no_repeat", 32'(EVT_VALID), 32'd0);
    end

    // Three simultaneous keys served 0,1,3
    KEY_UP = 4'b1011;
    step();
    KEY_UP = '0;
    step();
    check("rr_a", offer(), 32'b100);
    step();
    check("rr_a_gap", 32'(EVT_VALID), 32'd0);
    step();
    check("rr_b", offer(), 32'b101);
    step();
    check("rr_b_gap", 32'(EVT_VALID), 32'd0);
    step();
    check("rr_c", offer(), 32'b111);
    step();
    check("rr_c_gap", 32'(EVT_VALID), 32'd0);
    step();
    check("rr_drained", 32'(EVT_VALID), 32'd0);

    // rr_ptr back at 0: keys 0 and 3 pending must give 0 first
    KEY_UP = 4'b1001;
    step();
    KEY_UP = '0;
    step();
    check("ptr_wrap_first", offer(), 32'b100);
    step();
    step();
    check("ptr_wrap_second", offer(), 32'b111);
    step();
    check("ptr_wrap_done", 32'(EVT_VALID), 32'd0);

    // Held offer: stable for 50 cycles despite new key 3 pulses and LOCK
    EVT_ACK = 1'b0;
    KEY_UP  = 4'b0010;
    step();
    KEY_UP = '0;
    step();
    check("hold_offer", offer(), 32'b101);
    for (int i = 0; i < 50; i++) begin
      KEY_UP = (i % 5 == 0) ? 4'b1000 : 4'b0000;
      LOCK   = (i >= 25);
      step();
      check("hold_stable", offer(), 32'b101);
    end
    KEY_UP  = '0;
    LOCK    = 1'b0;
    EVT_ACK = 1'b1;
    step();
    check("hold_taken", 32'(EVT_VALID), 32'd0);
    step();
    check("hold_next", offer(), 32'b111);
    step();
    check("hold_drained", 32'(EVT_VALID), 32'd0);

`ifdef KEY_ARB_OVERFLOW_EN
    check("ovf_from_merges", 32'(OVF), 32'd1);
    OVF_CLR = 1'b1;
    step();
    OVF_CLR = 1'b0;
    check("ovf_cleared", 32'(OVF), 32'd0);
`endif

    // Re-press coincident with ack: set wins, key offered again
    EVT_ACK = 1'b0;
    KEY_UP  = 4'b0001;
    step();
    KEY_UP = '0;
    step();
    check("coin_offer", offer(), 32'b100);
    KEY_UP  = 4'b0001;
    EVT_ACK = 1'b1;
    step();
    KEY_UP = '0;
    check("coin_taken", 32'(EVT_VALID), 32'd0);
    step();
    check("coin_reoffer", offer(), 32'b100);
    step();
    step();
    check("coin_drained", 32'(EVT_VALID), 32'd0);
`ifdef KEY_ARB_OVERFLOW_EN
    check("coin_no_ovf", 32'(OVF), 32'd0);
`endif

    // LOCK discards new presses
    LOCK   = 1'b1;
    KEY_UP = 4'b1111;
    step();
    KEY_UP = '0;
    step();
    step();
    check("lock_no_event", 32'(EVT_VALID), 32'd0);
    LOCK = 1'b0;
    step();
    step();
    check("lock_no_pending", 32'(EVT_VALID), 32'd0);
`ifdef KEY_ARB_OVERFLOW_EN
    check("lock_no_ovf", 32'(OVF), 32'd0);

    // Two presses of key 0 before ack: one event, OVF sticky
    EVT_ACK = 1'b0;
    KEY_UP  = 4'b0001;
    step();
    KEY_UP = '0;
    step();
    check("ovf_offer", offer(), 32'b100);
    KEY_UP = 4'b0001;
    step();
    KEY_UP = '0;
    check("ovf_set", 32'(OVF), 32'd1);
    EVT_ACK = 1'b1;
    step();
    check("ovf_taken", 32'(EVT_VALID), 32'd0);
    step();
    check("ovf_single_event", 32'(EVT_VALID), 32'd0);
    step();
    check("ovf_sticky", 32'(OVF), 32'd1);
    OVF_CLR = 1'b1;
    step();
    OVF_CLR = 1'b0;
    check("ovf_clr", 32'(OVF), 32'd0);
`endif

    // Reset mid-offer drops the event asynchronously
    EVT_ACK = 1'b0;
    KEY_UP  = 4'b0100;
    step();
    KEY_UP = '0;
    step();
    check("rst_mid_offer", offer(), 32'b110);
    #2;
    CLR_N = 1'b0;
    #1;
    check("async_drop_valid", 32'(EVT_VALID), 32'd0);
    check("async_drop_code", 32'(EVT_CODE), 32'd0);
    @(negedge CLK);
    CLR_N = 1'b1;
    step();
    step();
    step();
    check("event_lost", 32'(EVT_VALID), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
Controller for a bank of KEYS_NUM switch debouncers in the countdown-timer front end.
- Generates the shared debounce sampling strobe and the per-key repeat enables.
- Latches each key's KEY_UP pulse into a pending flag.
- Serialises pending flags into a single valid/ack event stream using round-robin priority. The timer FSM consumes this stream.

Parameters:
KEYS_NUM, 4, number of debounced keys (2..16)
SAMPLE_PRESC_MODULO, 1000, CLK cycles per SAMPLE_CE pulse (>=2)
REPEAT_MASK, 4'b0011, bit i=1 allows auto-repeat for key i (width KEYS_NUM)
CODE_W, $clog2(KEYS_NUM), event code width (derived, not overridden)

Ports:
CLK  in  1  system clock, all logic on rising edge
CLR_N  in  1  asynchronous active-low reset
KEY_UP  in  KEYS_NUM  one-cycle press/repeat pulses from the debouncers
KEY_EN  in  KEYS_NUM  debounced held level from the debouncers
LOCK  in  1  1 = discard new KEY_UP pulses (pending flags untouched)
SAMPLE_CE  out  1  one-cycle debounce sampling strobe to all debouncers
REP_EN  out  KEYS_NUM  per-key repeat enable to the debouncers
EVT_VALID  out  1  event available
EVT_CODE  out  CODE_W  index of the key granted
EVT_ACK  in  1  consumer accepts the event while EVT_VALID=1

Behaviour:
- Reset (CLR_N=0, asynchronous) values:
  - Prescaler = 0; SAMPLE_CE = 0.
  - pending = 0; rr_ptr = 0; state = IDLE.
  - EVT_VALID = 0; EVT_CODE = 0; REP_EN = 0.
- Prescaler:
  - Counts 0..SAMPLE_PRESC_MODULO-1 and wraps.
  - SAMPLE_CE is registered and is 1 for exactly the one cycle after the counter holds MODULO-1.
  - The first pulse appears SAMPLE_PRESC_MODULO cycles after reset release.
- REP_EN (registered):
  - REP_EN[i] = REPEAT_MASK[i] & KEY_EN[i] & (popcount(KEY_EN)==1).
  - Chords therefore never auto-repeat.
- Pending:
  - pending[i] is set at the edge where KEY_UP[i]=1 and LOCK=0.
  - pending[i] is cleared at the edge where EVT_VALID=1, EVT_ACK=1 and EVT_CODE=i.
  - If clear and set coincide for the same key, set wins and the new event is kept.
  - A KEY_UP arriving while pending[i] is already 1 is merged (dropped).
- FSM states: IDLE, OFFER.
  - IDLE: if pending != 0, select the first set bit searching upward from rr_ptr with wrap. Register EVT_CODE, set EVT_VALID=1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: EVT_VALID and EVT_CODE are held stable until EVT_ACK.
  - On EVT_ACK: EVT_VALID=0, rr_ptr = (EVT_CODE+1) mod KEYS_NUM, go to IDLE.
  - Back-to-back events therefore have one idle bubble; maximum throughput is one event per 2 cycles.
  - EVT_ACK while EVT_VALID=0 is ignored.
- Latency: KEY_UP at edge t → pending at t+1 → EVT_VALID=1 after edge t+2 (2 cycles).
- LOCK does not withdraw an event already offered.
- Wrap: rr_ptr at KEYS_NUM-1 wraps to 0. The search is modulo KEYS_NUM and never yields a code >= KEYS_NUM.
- Reset mid-OFFER: the event is lost, and EVT_VALID drops asynchronously.

Optional Feature:
- Macro: KEY_ARB_OVERFLOW_EN.
- Defined:
  - Adds output OVF (1 bit), reset 0.
  - OVF sets sticky when a KEY_UP[i] is merged into an already-set pending[i]. The clear/set-coincident case does not count as a merge.
  - Adds input OVF_CLR (1 bit): clears OVF on the next edge. A simultaneous new merge wins and OVF stays 1.
- Not defined: no OVF/OVF_CLR ports, no related logic; the rest of the behaviour is identical.

Decomposition:
- Shared package (timer_pkg) holds:
  - FSM state encoding constants (ST_IDLE=0, ST_OFFER=1).
  - Default SAMPLE_PRESC_MODULO.
  - The key index constants used by the timer FSM (KEY_START, KEY_STOP, KEY_UP_MIN, KEY_DN_MIN).
- One natural sub-module: rr_pick. It is combinational with inputs pending and rr_ptr and outputs found and code, and is verified standalone.
- The prescaler stays inline.

Test Plan:
- Reset, then 3000 cycles with MODULO=1000 → SAMPLE_CE pulses at cycles 1000, 2000, 3000, each exactly 1 cycle wide.
- KEY_UP=4'b0100 for 1 cycle at t, EVT_ACK tied 1 → EVT_VALID=1, EVT_CODE=2 after edge t+2; pending clears; no second event.
- KEY_UP=4'b1011 in one cycle, rr_ptr=0, ack each offer immediately → codes 0,1,3 in order, rr_ptr ends at 0.
- Event offered for key 1, EVT_ACK held 0 for 50 cycles while KEY_UP[3] pulses → EVT_VALID/EVT_CODE=1 stable for all 50 cycles; after ack, code 3 is offered.
- KEY_EN=4'b0001 → REP_EN=4'b0001; KEY_EN=4'b0011 → REP_EN=0; KEY_EN=4'b0100 → REP_EN=0 (masked).
- With KEY_ARB_OVERFLOW_EN: two KEY_UP[0] pulses before any ack → OVF=1 and one event only; OVF_CLR → OVF=0. With LOCK=1, KEY_UP pulses → no pending set, no OVF.
